// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice: FSM states,
// ALU opcode encodings and datapath widths.
package alu_arb_pkg;

  localparam int DW  = 32;  // ALU data width
  localparam int OPW = 3;   // ALU opcode width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OPW-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [OPW-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [OPW-1:0] ALU_OP_AND = 3'b010;
  localparam logic [OPW-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [OPW-1:0] ALU_OP_XOR = 3'b100;
  localparam logic [OPW-1:0] ALU_OP_SLL = 3'b101;
  localparam logic [OPW-1:0] ALU_OP_SRL = 3'b110;
  localparam logic [OPW-1:0] ALU_OP_SLT = 3'b111;

endpackage

// File: rtl/alu1.sv
// ALU1: shared 32-bit combinational ALU. Shift amounts use B[4:0];
// SLT is an unsigned compare returning 0/1. Carry/overflow not produced.
module ALU1
  import alu_arb_pkg::*;
(
  input  logic [DW-1:0]  A,
  input  logic [DW-1:0]  B,
  input  logic [OPW-1:0] ALU_Sel,
  output logic [DW-1:0]  ALU_Result
);

  // Opcode decode; every encoding maps to a defined operation.
  always_comb begin
    ALU_Result = '0;
    case (ALU_Sel)
      ALU_OP_ADD: ALU_Result = A + B;
      ALU_OP_SUB: ALU_Result = A - B;
      ALU_OP_AND: ALU_Result = A & B;
      ALU_OP_OR:  ALU_Result = A | B;
      ALU_OP_XOR: ALU_Result = A ^ B;
      ALU_OP_SLL: ALU_Result = A << B[4:0];
      ALU_OP_SRL: ALU_Result = A >> B[4:0];
      ALU_OP_SLT: ALU_Result = {{(DW-1){1'b0}}, (A < B)};
      default:    ALU_Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching from
// ptr_i upward and wrapping NREQ-1 -> 0. Outputs one-hot grant, its index,
// and whether any request is present.
module alu_rr_pick #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int             j;
  logic [IDW-1:0] j_idx;
  logic           found;

  // Rotate the search start to ptr_i; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      j_idx = IDW'(j);
      if (!found && req_i[j_idx]) begin
        found        = 1'b1;
        gnt_o[j_idx] = 1'b1;
        idx_o        = j_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU1 between NREQ requesters. Round-robin grant
// in IDLE, one cycle of execution from latched operands, then the result
// is held on a valid/ready response channel until consumed.
// Optional: define ALU_ARB_ZERO_FLAG_EN to add rsp_zero (result == 0),
// registered and held alongside rsp_data.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic [IDW-1:0]     rsp_id,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic               rsp_zero,
`endif
  output logic               busy
);

  // Per-requester views of the flat operand buses.
  logic [NREQ-1:0][DW-1:0]  a_v, b_v;
  logic [NREQ-1:0][OPW-1:0] op_v;

  assign a_v  = req_a;
  assign b_v  = req_b;
  assign op_v = req_op;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q;
  logic [DW-1:0]   a_q, b_q;
  logic [OPW-1:0]  op_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic [IDW-1:0]  rsp_id_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic            rsp_zero_q;
`endif

  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_idx;
  logic            pick_any;
  logic [DW-1:0]   alu_res;

  alu_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  ALU1 u_alu (
    .A          (a_q),
    .B          (b_q),
    .ALU_Sel    (op_q),
    .ALU_Result (alu_res)
  );

  // Next pointer sits one past the winner so it has lowest priority next time.
  assign ptr_d = (pick_idx == IDW'(NREQ-1)) ? '0 : pick_idx + 1'b1;

  // Accept strobe only in IDLE; masked while reset is held so the
  // requesters never see a grant that cannot be latched.
  assign req_ready = (state_q == IDLE && rst_n) ? pick_gnt : '0;

  // Arbiter FSM: grant/latch, execute, hold response until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef ALU_ARB_ZERO_FLAG_EN
      rsp_zero_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            a_q     <= a_v[pick_idx];
            b_q     <= b_v[pick_idx];
            op_q    <= op_v[pick_idx];
            gnt_q   <= pick_idx;
            ptr_q   <= ptr_d;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_res;
          rsp_id_q    <= gnt_q;
          rsp_valid_q <= 1'b1;
`ifdef ALU_ARB_ZERO_FLAG_EN
          rsp_zero_q  <= (alu_res == '0);
`endif
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
`ifdef ALU_ARB_ZERO_FLAG_EN
  assign rsp_zero  = rsp_zero_q;
`endif
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: an accept monitor predicts the grant
// and result from a behavioural model and queues it; a response monitor
// pops and compares on every response handshake.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       rv;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] ra, rb;
  logic [NREQ-1:0][2:0]  rop;
  logic                  rsp_valid, rsp_ready, busy;
  logic [31:0]           rsp_data;
  logic [IDW-1:0]        rsp_id;
`ifdef ALU_ARB_ZERO_FLAG_EN
  logic                  rsp_zero;
`endif

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_ready (req_ready),
    .req_a     (ra),
    .req_b     (rb),
    .req_op    (rop),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
`ifdef ALU_ARB_ZERO_FLAG_EN
    .rsp_zero  (rsp_zero),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   got_ids[$];
  int   got_cyc[$];
  logic got_zero[$];
  int   checks = 0;
  int   errors = 0;
  int   mptr   = 0;

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % 32);
      3'd6: return a >> (b % 32);
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Round-robin reference: first valid starting at p, modulo NREQ.
  function automatic int ref_pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[IDW'(i)]) return i;
    end
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(string nm);
    checks++;
    errors++;
    $display("FAIL timeout %s (t=%0t)", nm, $time);
  endtask

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    ra[IDW'(i)]  = a;
    rb[IDW'(i)]  = b;
    rop[IDW'(i)] = op;
    rv[IDW'(i)]  = 1'b1;
  endtask

  function automatic logic [31:0] rnd_opnd();
    return ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
  endfunction

  // Accept monitor: predicts grant and queues the expected response.
  task automatic acc_mon();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mptr = 0;
      end else if (busy) begin
        chk("ready_while_busy", 64'(req_ready), 64'(0));
      end else if (rv != '0) begin
        int g;
        logic [NREQ-1:0] oh;
        exp_t e;
        g  = ref_pick(rv, mptr);
        oh = '0;
        oh[IDW'(g)] = 1'b1;
        chk("grant", 64'(req_ready), 64'(oh));
        e.id   = g;
        e.data = ref_alu(ra[IDW'(g)], rb[IDW'(g)], rop[IDW'(g)]);
        e.zero = (e.data == 32'h0);
        e.cyc  = cyc;
        exp_q.push_back(e);
        mptr = (g + 1) % NREQ;
      end else begin
        chk("ready_idle", 64'(req_ready), 64'(0));
      end
    end
  endtask

  // Response monitor: latency, hold-stability and data/id on handshake.
  task automatic rsp_mon();
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    logic [IDW-1:0] pid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (rsp_valid && pv && !pr) begin
          chk("hold_data", 64'(rsp_data), 64'(pd));
          chk("hold_id", 64'(rsp_id), 64'(pid));
        end
        if (rsp_valid && !pv) begin
          if (exp_q.size() == 0) tmo("unexpected_rsp");
          else chk("latency", 64'(cyc - exp_q[0].cyc), 64'(2));
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
`ifdef ALU_ARB_ZERO_FLAG_EN
          chk("rsp_zero", 64'(rsp_zero), 64'(e.zero));
          got_zero.push_back(rsp_zero);
`endif
          got_ids.push_back(int'(rsp_id));
          got_cyc.push_back(cyc);
        end
        pv = rsp_valid; pr = rsp_ready; pd = rsp_data; pid = rsp_id;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((exp_q.size() != 0 || busy) && n < 100);
    if (n >= 100) tmo("drain");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rv = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic one_shot(int i, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    int n = 0;
    @(posedge clk); #1;
    set_req(i, a, b, op);
    do begin @(negedge clk); n++; end
    while (req_ready[IDW'(i)] !== 1'b1 && n < 50);
    if (n >= 50) tmo("one_shot_grant");
    @(posedge clk); #1;
    rv[IDW'(i)] = 1'b0;
    drain();
  endtask

  // Raise every requester in mask; each drops after its own grant.
  task automatic serve(logic [NREQ-1:0] mask);
    logic [NREQ-1:0] r;
    int n = 0;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++)
      if (mask[IDW'(i)]) set_req(i, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
    while (rv != '0 && n < 100) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      rv = rv & ~r;
      n++;
    end
    if (rv != '0) begin tmo("serve"); rv = '0; end
    drain();
  endtask

  initial begin
    logic [NREQ-1:0] r;
    logic [31:0] hd;
    logic [IDW-1:0] hid;
    int n, bad;
    int exp_seq[5] = '{0, 1, 2, 3, 0};

    rst_n = 1'b0; rv = '1; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_opnd(), rnd_opnd(), 3'd0);
    fork
      acc_mon();
      rsp_mon();
    join_none

    // Reset values, with all requesters asserting valid.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(rsp_data), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    rv = '0; rst_n = 1'b1;

    // Single directed add.
    @(posedge clk); #1;
    set_req(0, 32'h12345678, 32'hAABBCCDD, 3'b000);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1 rv[0] = 1'b0;
    @(negedge clk);
    chk("single_exec_valid", 64'(rsp_valid), 64'(0));
    chk("single_exec_busy", 64'(busy), 64'(1));
    @(negedge clk);
    chk("single_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("single_rsp_data", 64'(rsp_data), 64'(32'hBCF02355));
    chk("single_rsp_id", 64'(rsp_id), 64'(0));
    drain();

    // Contention: all four held valid from ptr=0.
    do_reset();
    got_ids.delete(); got_cyc.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
    n = 0;
    while (got_ids.size() < 5 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1 rv = '0;
    drain();
    if (got_ids.size() < 5) tmo("contention");
    else begin
      for (int k = 0; k < 5; k++) chk("contention_id", 64'(got_ids[k]), 64'(exp_seq[k]));
      for (int k = 1; k < 5; k++) chk("contention_gap", 64'(got_cyc[k] - got_cyc[k-1]), 64'(3));
    end

    // Wrap/skip: move ptr to 3, then 1 and 2 contend, then 3 must be next.
    do_reset();
    serve(4'b0100);
    got_ids.delete();
    serve(4'b0110);
    if (got_ids.size() != 2) tmo("wrap_count");
    else begin
      chk("wrap_first", 64'(got_ids[0]), 64'(1));
      chk("wrap_second", 64'(got_ids[1]), 64'(2));
    end
    got_ids.delete();
    serve(4'b1001);
    if (got_ids.size() != 2) tmo("ptr_end_count");
    else chk("ptr_end_at_3", 64'(got_ids[0]), 64'(3));

    // Backpressure: hold response 5 cycles with another requester waiting.
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    set_req(0, 32'h0000_00F0, 32'h0000_000F, 3'b011);
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready[0] !== 1'b1 && n < 50);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    set_req(1, rnd_opnd(), rnd_opnd(), 3'b000);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    if (!rsp_valid) tmo("bp_rsp");
    hd = rsp_data; hid = rsp_id;
    chk("bp_data", 64'(hd), 64'(32'h0000_00FF));
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_data_hold", 64'(rsp_data), 64'(hd));
      chk("bp_id_hold", 64'(rsp_id), 64'(hid));
      chk("bp_ready", 64'(req_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_valid", 64'(rsp_valid), 64'(0));
    chk("bp_release_busy", 64'(busy), 64'(0));
    @(posedge clk); #1 rv = '0;
    drain();

    // Reset during EXEC: transaction discarded.
    @(posedge clk); #1;
    set_req(2, rnd_opnd(), rnd_opnd(), 3'b100);
    @(negedge clk);
    chk("rstop_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1;
    rv = '0;
    chk("rstop_exec_busy", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rstop_valid", 64'(rsp_valid), 64'(0));
    chk("rstop_busy", 64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    repeat (8) begin @(negedge clk); if (rsp_valid) bad++; end
    chk("rstop_no_rsp", 64'(bad), 64'(0));

`ifdef ALU_ARB_ZERO_FLAG_EN
    got_zero.delete();
    one_shot(1, 32'h5, 32'h5, 3'b000);
    one_shot(1, 32'h5, 32'h5, 3'b001);
    if (got_zero.size() != 2) tmo("zero_count");
    else begin
      chk("zero_add", 64'(got_zero[0]), 64'(0));
      chk("zero_sub", 64'(got_zero[1]), 64'(1));
    end
`endif

    // Random traffic with random backpressure and legal early drops.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); r = req_ready;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (r[IDW'(i)]) begin
          if ($urandom_range(0, 1) == 1) set_req(i, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
          else rv[IDW'(i)] = 1'b0;
        end else if (rv[IDW'(i)]) begin
          if ($urandom_range(0, 15) == 0) rv[IDW'(i)] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, rnd_opnd(), rnd_opnd(), 3'($urandom_range(0, 7)));
        end
      end
    end
    @(negedge clk); r = req_ready;
    @(posedge clk); #1;
    rv = '0; rsp_ready = 1'b1;
    drain();
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
